cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Two-to-one arbiter between the instruction cache and data cache downstream ports and the single shared memory port (L2 or physical memory).
Each cache's control FSM issues whole-line read/write requests and holds them until it sees its response. The arbiter grants one requester at a time and registers the request at grant. It then drives the memory port and steers mem_resp back to the granted cache only.
Round-robin fairness prevents either cache starving the other.

Parameters:
LINE_WIDTH, 256, cache line width in bits (data buses)
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
i_read  input  1  I-cache line read request
i_address  input  ADDR_WIDTH  I-cache line address
i_rdata  output  LINE_WIDTH  line data to I-cache
i_resp  output  1  I-cache transaction complete
d_read  input  1  D-cache line read request
d_write  input  1  D-cache line writeback request
d_address  input  ADDR_WIDTH  D-cache line address
d_wdata  input  LINE_WIDTH  D-cache writeback data
d_rdata  output  LINE_WIDTH  line data to D-cache
d_resp  output  1  D-cache transaction complete
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_address  output  ADDR_WIDTH  memory address
mem_wdata  output  LINE_WIDTH  memory write data
mem_rdata  input  LINE_WIDTH  memory read data
mem_resp  input  1  memory transaction complete (1-cycle pulse)

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Registers: state, last_grant (0=I, 1=D), latched op (read/write), address, wdata.
- Reset (rst=1 at posedge): state=IDLE, last_grant=D (so I wins the first tie), latches cleared to 0. Outputs after reset: mem_read=mem_write=i_resp=d_resp=0, mem_address=0, mem_wdata=0.
- Reset mid-transaction: abandons it, returns to IDLE and issues no response. The memory side is reset by the same rst.
- IDLE: all outputs to memory are deasserted; resps are 0.
  - Request pending: i_read, or d_read|d_write.
  - Only one side pending: grant it.
  - Both pending: grant the side not equal to last_grant.
  - On grant, register address/op/wdata from the granted port, set last_grant, and move to SERVE_I or SERVE_D at the next edge.
- Latency: a request sampled in IDLE at edge t causes mem_read/mem_write from the cycle after t. Minimum arbiter overhead is 1 cycle per transaction.
- SERVE_x: mem_read/mem_write, mem_address and mem_wdata are driven from the latched registers and held constant until mem_resp.
  - In the cycle mem_resp=1, assert the granted side's resp combinationally (i_resp or d_resp, never both). The other resp stays 0.
  - Next state is IDLE.
  - With mem_resp=0, remain in SERVE_x.
- After a response, the arbiter always spends one cycle in IDLE.
  - The requester's FSM has left its request state by then, so a stale request is never re-granted.
  - A D-cache read that immediately follows its own writeback is re-arbitrated normally.
- Both i_rdata and d_rdata are driven continuously with mem_rdata. Only the resp signals are gated.
- d_read and d_write both high (illegal): treated as a write. mem_read and mem_write are never asserted together.
- Inputs that change after grant are ignored until the next IDLE.
- mem_resp in IDLE (spurious) is ignored and no resp is forwarded.

Test Plan:
1. Reset, then i_read=1, i_address=0x0000_1000 → mem_read=1 with mem_address=0x1000 from the next cycle. Memory answers after 5 cycles with rdata=0xA5…A5 → i_resp=1 for exactly that cycle, d_resp=0, i_rdata=0xA5…A5, then IDLE.
2. Single D writeback: d_write=1, d_address=0x0000_2040, d_wdata=pattern P → mem_write=1, mem_wdata=P, mem_read=0 until mem_resp; d_resp pulses once; i_resp stays 0.
3. Simultaneous i_read and d_read held continuously, out of reset → grant order I, D, I, D over 4 transactions. Each resp appears only on the granted side; each grant is separated by one IDLE cycle.
4. Mid-transaction input change: grant D read at 0x3000, then change d_address to 0x4000 → mem_address stays 0x3000 until mem_resp.
5. rst asserted 2 cycles into a SERVE_I with mem_resp not yet returned → next cycle state=IDLE, mem_read=0, and no i_resp is ever emitted. A mem_resp arriving in IDLE is ignored.
6. d_read=d_write=1 → mem_write=1, mem_read=0. A spurious mem_resp pulse while idle produces no i_resp or d_resp.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Bundle of all cache-side and memory-side signals seen by cache_arbiter.
//   slave  : arbiter view (takes cache requests / memory responses, drives
//            memory requests / cache responses)
//   master : environment view (caches plus memory), the mirror image
// Signals:
//   i_read, i_address, i_rdata, i_resp                 I-cache port
//   d_read, d_write, d_address, d_wdata, d_rdata, d_resp  D-cache port
//   mem_read, mem_write, mem_address, mem_wdata,
//   mem_rdata, mem_resp                                shared memory port
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-to-one round-robin arbiter between the I-cache and D-cache line ports
// and one shared memory port. One request is granted at a time; its op,
// address and write data are captured at grant and replayed to memory until
// mem_resp, which is then steered to the granted cache only.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : synchronous active-high reset
//   bus  : cache_arbiter_if.slave carrying the cache and memory signals
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    cache_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [LINE_WIDTH-1:0] r_wdata;

    logic                  w_i_pending;
    logic                  w_d_pending;
    logic                  w_grant;
    logic                  w_grant_d;
    logic                  w_grant_write;
    logic [ADDR_WIDTH-1:0] w_grant_address;
    logic [LINE_WIDTH-1:0] w_grant_wdata;

    assign w_i_pending = bus.i_read;
    assign w_d_pending = bus.d_read | bus.d_write;

    // Payload captured at grant; read+write together from the D side is a write.
    assign w_grant_write   = w_grant_d & bus.d_write;
    assign w_grant_address = w_grant_d ? bus.d_address : bus.i_address;
    assign w_grant_wdata   = w_grant_d ? bus.d_wdata : {LINE_WIDTH{1'b0}};

    // Grant decision and next-state: arbitration only happens in IDLE.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_d   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_i_pending && w_d_pending) begin
                    // Tie: the side that did not win last time goes next.
                    w_grant   = 1'b1;
                    w_grant_d = (r_last_grant == GRANT_I);
                end else if (w_i_pending) begin
                    w_grant   = 1'b1;
                    w_grant_d = 1'b0;
                end else if (w_d_pending) begin
                    w_grant   = 1'b1;
                    w_grant_d = 1'b1;
                end else begin
                    w_grant   = 1'b0;
                    w_grant_d = 1'b0;
                end
                if (w_grant) begin
                    w_state_nxt = w_grant_d ? SERVE_D : SERVE_I;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                // Always drop back to IDLE for one cycle after a response so
                // the requester has left its request state before re-arbitration.
                if (bus.mem_resp) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus the request latches loaded only at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_D;
            r_op_write   <= 1'b0;
            r_address    <= {ADDR_WIDTH{1'b0}};
            r_wdata      <= {LINE_WIDTH{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_grant <= w_grant_d;
                r_op_write   <= w_grant_write;
                r_address    <= w_grant_address;
                r_wdata      <= w_grant_wdata;
            end else begin
                r_last_grant <= r_last_grant;
                r_op_write   <= r_op_write;
                r_address    <= r_address;
                r_wdata      <= r_wdata;
            end
        end
    end

    // Memory request driven from the latches while serving; resp steered to the owner.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = {ADDR_WIDTH{1'b0}};
        bus.mem_wdata   = {LINE_WIDTH{1'b0}};
        bus.i_resp      = 1'b0;
        bus.d_resp      = 1'b0;
        case (r_state)
            SERVE_I, SERVE_D: begin
                bus.mem_read    = ~r_op_write;
                bus.mem_write   = r_op_write;
                bus.mem_address = r_address;
                bus.mem_wdata   = r_wdata;
                bus.i_resp      = (r_state == SERVE_I) & bus.mem_resp;
                bus.d_resp      = (r_state == SERVE_D) & bus.mem_resp;
            end
            default: begin
                bus.mem_read = 1'b0;
            end
        endcase
    end

    // Read data is broadcast; only the resp strobes qualify it.
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus();

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference: at most one outstanding transaction,
    // chosen round-robin from whoever is asking when the arbiter is free.
    // ------------------------------------------------------------------
    bit            m_valid = 1'b0;
    bit            m_busy;
    bit            m_side;      // 0 = I, 1 = D
    bit            m_write;
    bit            m_last;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit            want_i;
    bit            want_d;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_last  = 1'b1;
            m_side  = 1'b0;
            m_write = 1'b0;
            m_addr  = '0;
            m_wdata = '0;
        end else if (m_busy) begin
            if (bus.mem_resp) m_busy = 1'b0;
        end else begin
            want_i = bus.i_read;
            want_d = bus.d_read | bus.d_write;
            if (want_i || want_d) begin
                m_side  = (want_i && want_d) ? !m_last : want_d;
                m_last  = m_side;
                m_busy  = 1'b1;
                m_write = m_side && bus.d_write;
                m_addr  = m_side ? bus.d_address : bus.i_address;
                m_wdata = m_side ? bus.d_wdata : '0;
            end
        end
    end

    // Every-cycle comparison against the reference, mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("mem_read",    LW'(bus.mem_read),    LW'(m_busy && !m_write));
            check("mem_write",   LW'(bus.mem_write),   LW'(m_busy && m_write));
            check("mem_address", LW'(bus.mem_address), m_busy ? LW'(m_addr) : '0);
            check("mem_wdata",   bus.mem_wdata,        m_busy ? m_wdata : '0);
            check("i_resp",      LW'(bus.i_resp),      LW'(m_busy && !m_side && bus.mem_resp));
            check("d_resp",      LW'(bus.d_resp),      LW'(m_busy && m_side && bus.mem_resp));
            check("i_rdata",     bus.i_rdata,          bus.mem_rdata);
            check("d_rdata",     bus.d_rdata,          bus.mem_rdata);
        end
    end

    logic [LW-1:0] pat_a5;
    logic [LW-1:0] pat_p;
    bit            exp_d_seq [4];

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_p  = {8{32'hC0FFEE11}};
        exp_d_seq[0] = 1'b0; exp_d_seq[1] = 1'b1;
        exp_d_seq[2] = 1'b0; exp_d_seq[3] = 1'b1;

        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = 1'b0;
        rst = 1'b1;
        step(); step();
        @(negedge clk);
        check("t1_rst_mem_read",  LW'(bus.mem_read), '0);
        check("t1_rst_mem_addr",  LW'(bus.mem_address), '0);
        check("t1_rst_resp",      LW'({bus.i_resp, bus.d_resp}), '0);

        // 1: single I read, 5-cycle memory latency
        step();
        rst = 1'b0; bus.i_read = 1'b1; bus.i_address = 32'h0000_1000;
        step();
        @(negedge clk);
        check("t1_mem_read", LW'(bus.mem_read), LW'(1'b1));
        check("t1_mem_addr", LW'(bus.mem_address), LW'(32'h0000_1000));
        repeat (4) step();
        bus.mem_resp = 1'b1; bus.mem_rdata = pat_a5;
        @(negedge clk);
        check("t1_i_resp", LW'(bus.i_resp), LW'(1'b1));
        check("t1_d_resp", LW'(bus.d_resp), '0);
        check("t1_i_rdata", bus.i_rdata, pat_a5);
        step();
        bus.mem_resp = 1'b0; bus.i_read = 1'b0;
        @(negedge clk);
        check("t1_idle_mem_read", LW'(bus.mem_read), '0);
        check("t1_i_resp_pulse", LW'(bus.i_resp), '0);

        // 2: D writeback
        bus.d_write = 1'b1; bus.d_address = 32'h0000_2040; bus.d_wdata = pat_p;
        step();
        @(negedge clk);
        check("t2_mem_write", LW'(bus.mem_write), LW'(1'b1));
        check("t2_mem_read",  LW'(bus.mem_read), '0);
        check("t2_mem_wdata", bus.mem_wdata, pat_p);
        step(); step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        check("t2_d_resp", LW'(bus.d_resp), LW'(1'b1));
        check("t2_i_resp", LW'(bus.i_resp), '0);
        step();
        bus.mem_resp = 1'b0; bus.d_write = 1'b0;

        // 3: both reading continuously from reset -> I, D, I, D
        rst = 1'b1;
        step();
        rst = 1'b0; bus.i_read = 1'b1; bus.d_read = 1'b1;
        bus.i_address = 32'h0000_0100; bus.d_address = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.mem_resp = 1'b1;
            @(negedge clk);
            check("t3_mem_read", LW'(bus.mem_read), LW'(1'b1));
            check("t3_i_resp", LW'(bus.i_resp), LW'(!exp_d_seq[k]));
            check("t3_d_resp", LW'(bus.d_resp), LW'(exp_d_seq[k]));
            step();
            bus.mem_resp = 1'b0;
            @(negedge clk);
            check("t3_idle_gap", LW'(bus.mem_read), '0);
        end

        // 4: address change after grant is ignored
        bus.i_read = 1'b0; bus.d_read = 1'b1; bus.d_address = 32'h0000_3000;
        step();
        bus.d_address = 32'h0000_4000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_mem_addr", LW'(bus.mem_address), LW'(32'h0000_3000));
            step();
        end
        bus.mem_resp = 1'b1;
        @(negedge clk);
        check("t4_d_resp", LW'(bus.d_resp), LW'(1'b1));
        step();
        bus.mem_resp = 1'b0; bus.d_read = 1'b0;

        // 5: reset in the middle of SERVE_I, then a late mem_resp
        bus.i_read = 1'b1; bus.i_address = 32'h0000_5000;
        step();
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0; bus.i_read = 1'b0;
        @(negedge clk);
        check("t5_mem_read", LW'(bus.mem_read), '0);
        check("t5_i_resp", LW'(bus.i_resp), '0);
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        check("t5_late_resp", LW'({bus.i_resp, bus.d_resp}), '0);
        step();
        bus.mem_resp = 1'b0;

        // 6: read+write together is a write; spurious resp while idle
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h0000_6000;
        step();
        @(negedge clk);
        check("t6_mem_write", LW'(bus.mem_write), LW'(1'b1));
        check("t6_mem_read",  LW'(bus.mem_read), '0);
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        check("t6_d_resp", LW'(bus.d_resp), LW'(1'b1));
        step();
        bus.mem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        check("t6_spurious", LW'({bus.i_resp, bus.d_resp}), '0);
        step();
        bus.mem_resp = 1'b0;

        // Randomized traffic, checked every cycle against the reference
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.i_read    = ($urandom_range(0, 2) != 0);
            bus.i_address = $urandom;
            bus.d_read    = ($urandom_range(0, 2) == 0);
            bus.d_write   = ($urandom_range(0, 3) == 0);
            bus.d_address = $urandom;
            bus.d_wdata   = rand_line();
            bus.mem_rdata = rand_line();
            bus.mem_resp  = ($urandom_range(0, 3) == 0);
            step();
        end
        rst = 1'b0;
        bus.mem_resp = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
